// File: rtl/instr_fetch.sv
// instr_fetch: RISC-V fetch stage; holds the PC, fetches words over req/ack, presents instr to decode.
// Ports: clk/reset (async, active-high); imem_req/imem_addr/imem_ack/imem_rdata memory handshake;
// instr/instr_valid/instr_ready decode handshake; pc, pc_plus4; pc_src/imm_ext/jalr_target next-PC inputs;
// misalign fault flag.
// Option: MISALIGN_TRAP_EN traps misaligned targets in FAULT; otherwise targets are forced word-aligned.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic [1:0]  pc_src,
  input  logic [31:0] imm_ext,
  input  logic [31:0] jalr_target,
  output logic        misalign
);
  typedef enum logic [1:0] {
    IDLE,
    REQ,
`ifdef MISALIGN_TRAP_EN
    FAULT,
`endif
    HOLD
  } state_t;
  state_t state;
  logic [31:0] next_pc;
  assign imem_addr = pc;
  assign pc_plus4 = pc + 32'd4;
  always_comb next_pc = (pc_src == 2'b01) ? pc + imm_ext :
                        (pc_src == 2'b10) ? {jalr_target[31:1], 1'b0} : pc_plus4;
`ifndef MISALIGN_TRAP_EN
  assign misalign = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= 32'h0000_0013;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
        end
        REQ: if (imem_ack) begin
          instr       <= imem_rdata;
          instr_valid <= 1'b1;
          imem_req    <= 1'b0;
          state       <= HOLD;
        end
        HOLD: if (instr_ready) begin
          instr_valid <= 1'b0;
`ifdef MISALIGN_TRAP_EN
          pc <= next_pc;
          if (next_pc[1:0] != 2'b00) begin
            misalign <= 1'b1;
            state    <= FAULT;
          end else begin
            imem_req <= 1'b1;
            state    <= REQ;
          end
`else
          pc       <= next_pc & ~32'h3;
          imem_req <= 1'b1;
          state    <= REQ;
`endif
        end
`ifdef MISALIGN_TRAP_EN
        FAULT: state <= FAULT;
`endif
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [1:0]  pc_src;
  logic [31:0] imm_ext;
  logic [31:0] jalr_target;
  logic        misalign;
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_pc;
  logic        exp_fault;

  instr_fetch #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .pc(pc),
    .pc_plus4(pc_plus4), .pc_src(pc_src), .imm_ext(imm_ext),
    .jalr_target(jalr_target), .misalign(misalign)
  );

  always #5 clk = ~clk;

  // Reference next-PC rule: plain 32-bit wrapping arithmetic on the selected source.
  function automatic logic [31:0] model_target(logic [31:0] p, logic [1:0] s, logic [31:0] imm, logic [31:0] jt);
    if (s == 2'd1) return p + imm;
    if (s == 2'd2) return jt & 32'hFFFF_FFFE;
    return p + 32'd4;
  endfunction

  // One full instruction transaction from the first REQ cycle through the consume edge.
  task automatic fetch_one(input int w, input int h, input logic [1:0] s, input logic [31:0] imm, input logic [31:0] jt);
    logic [31:0] r, tgt;
    r = $urandom;
    for (int i = 0; i <= w; i++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
        failures++;
        $display("FAIL req_phase: req=%b addr=%h required req=1 addr=%h", imem_req, imem_addr, exp_pc);
      end
      imem_ack = (i == w);
      imem_rdata = (i == w) ? r : $urandom;
      instr_ready = $urandom_range(0, 1);
      @(negedge clk);
    end
    imem_ack = 1'b1;
    imem_rdata = $urandom;
    for (int i = 0; i <= h; i++) begin
      checks++;
      if (instr_valid !== 1'b1 || instr !== r || pc !== exp_pc || imem_req !== 1'b0 || pc_plus4 !== exp_pc + 32'd4) begin
        failures++;
        $display("FAIL hold_phase: valid=%b instr=%h pc=%h req=%b pc4=%h required 1 %h %h 0 %h",
                 instr_valid, instr, pc, imem_req, pc_plus4, r, exp_pc, exp_pc + 32'd4);
      end
      instr_ready = (i == h);
      pc_src = s;
      imm_ext = imm;
      jalr_target = jt;
      @(negedge clk);
    end
    imem_ack = 1'b0;
    instr_ready = 1'b0;
    pc_src = $urandom;
    imm_ext = $urandom;
    jalr_target = $urandom;
    tgt = model_target(exp_pc, s, imm, jt);
`ifdef MISALIGN_TRAP_EN
    exp_pc = tgt;
    exp_fault = (tgt[1:0] != 2'b00);
`else
    exp_pc = {tgt[31:2], 2'b00};
    exp_fault = 1'b0;
`endif
    checks++;
    if (pc !== exp_pc || instr_valid !== 1'b0 || imem_req !== !exp_fault || misalign !== exp_fault) begin
      failures++;
      $display("FAIL consume: pc=%h valid=%b req=%b mis=%b required %h 0 %b %b",
               pc, instr_valid, imem_req, misalign, exp_pc, !exp_fault, exp_fault);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    imem_ack = 1'b0;
    instr_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    exp_pc = RST_PC;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    instr_ready = 1'b0;
    pc_src = 2'b00;
    imm_ext = 32'h0;
    jalr_target = 32'h0;
    @(negedge clk);
    checks++;
    if (pc !== RST_PC || instr !== 32'h13 || instr_valid !== 1'b0 || imem_req !== 1'b0 || misalign !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: pc=%h instr=%h valid=%b req=%b mis=%b", pc, instr, instr_valid, imem_req, misalign);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
      failures++;
      $display("FAIL first_req: req=%b addr=%h required 1 %h", imem_req, imem_addr, RST_PC);
    end
    exp_pc = RST_PC;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) fetch_one(0, 0, 2'b00, 32'h0, 32'h0);
    checks++;
    if (imem_addr !== 32'h0000_000C) begin
      failures++;
      $display("FAIL seq_addr: addr=%h required 0000000c", imem_addr);
    end
  endtask

  task automatic test_branch_wrap();
    fetch_one(0, 0, 2'b10, 32'h0, 32'h0000_0010);
    fetch_one(0, 0, 2'b01, 32'hFFFF_FFF8, 32'h0);
    checks++;
    if (imem_addr !== 32'h0000_0008) begin
      failures++;
      $display("FAIL branch_back: addr=%h required 00000008", imem_addr);
    end
    fetch_one(0, 0, 2'b10, 32'h0, 32'hFFFF_FFFC);
    fetch_one(0, 0, 2'b00, 32'h0, 32'h0);
    checks++;
    if (imem_addr !== 32'h0000_0000) begin
      failures++;
      $display("FAIL wrap: addr=%h required 00000000", imem_addr);
    end
  endtask

  task automatic test_jalr();
    fetch_one(0, 0, 2'b10, 32'h0, 32'h0000_0103);
`ifdef MISALIGN_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      imem_ack = 1'b1;
      instr_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (misalign !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h102) begin
        failures++;
        $display("FAIL fault_hold: mis=%b req=%b valid=%b pc=%h required 1 0 0 00000102", misalign, imem_req, instr_valid, pc);
      end
    end
    apply_reset();
`else
    checks++;
    if (imem_addr !== 32'h0000_0100) begin
      failures++;
      $display("FAIL jalr_align: addr=%h required 00000100", imem_addr);
    end
`endif
  endtask

  task automatic test_waits();
    fetch_one(3, 2, 2'b00, 32'h0, 32'h0);
    fetch_one(1, 0, 2'b01, 32'h0000_0020, 32'h0);
  endtask

  task automatic test_reset_mid();
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    reset = 1'b1;
    #1;
    checks++;
    if (pc !== RST_PC || instr !== 32'h13 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_req: pc=%h instr=%h req=%b valid=%b", pc, instr, imem_req, instr_valid);
    end
    @(negedge clk);
    checks++;
    if (instr !== 32'h13) begin
      failures++;
      $display("FAIL reset_ack_drop: instr=%h required 00000013", instr);
    end
    reset = 1'b0;
    imem_ack = 1'b0;
    @(negedge clk);
    exp_pc = RST_PC;
    fetch_one(0, 1, 2'b00, 32'h0, 32'h0);
    imem_ack = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (pc !== RST_PC || instr !== 32'h13 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_hold: pc=%h instr=%h valid=%b", pc, instr, instr_valid);
    end
    reset = 1'b0;
    imem_ack = 1'b0;
    @(negedge clk);
    exp_pc = RST_PC;
  endtask

  task automatic test_random();
    logic [31:0] imm, jt;
    for (int i = 0; i < 40; i++) begin
      imm = $urandom;
      jt = $urandom;
`ifdef MISALIGN_TRAP_EN
      imm[1:0] = 2'b00;
      jt[1:0] = 2'b00;
`endif
      fetch_one($urandom_range(0, 3), $urandom_range(0, 2), 2'($urandom_range(0, 3)), imm, jt);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch_wrap();
    test_jalr();
    test_waits();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
